riscv_fetch_pc_sequencer: RTL and testbench
===========================================

Name: riscv_fetch_pc_sequencer

Overview:
- Fetch-stage next-PC generator; sits directly downstream of the next-address predictor and drives the IF address back into it.
- Selects the next PC from EX redirects, predictor rollbacks, predictor injections or sequential +4.
- Generates per-stage kill flags for PM/ID/EX and traps misaligned architectural redirects.
- Optionally keeps fetch performance counters.

Parameters:
ADDR_WIDTH, 64, width of all PCs/addresses
RESET_ADDR, 0, PC loaded on reset
TRAP_ADDR, 'h100, PC loaded on misaligned architectural redirect
CNT_WIDTH, 32, width of each performance counter

Ports:
clk  in  1  clock
nreset  in  1  reset
i_stall  in  1  pipeline stall; sequencer state frozen while 1
i_ex_jump_branch  in  1  EX resolves a taken jump/branch this cycle
i_ex_jump_addr  in  ADDR_WIDTH  EX target
i_discard_jump  in  1  predictor: EX jump already correctly predicted
i_rollback_jump  in  1  predictor: mispredicted taken, return to fall-through
i_rollback_jump_addr  in  ADDR_WIDTH  fall-through address
i_pm_flush_req  in  1  predictor: instruction now in IF is wrong path
i_if_inject  in  1  predictor: fetch from inject address next
i_if_inject_addr  in  ADDR_WIDTH  predicted target
o_if_pc  out  ADDR_WIDTH  current fetch PC (reg)
o_pm_flush  out  1  PM stage holds killed instruction (reg)
o_id_flush  out  1  ID stage holds killed instruction (reg)
o_ex_flush  out  1  EX stage holds killed instruction (reg)
o_redirect  out  1  architectural redirect taken last cycle (reg pulse)
o_fetch_misaligned  out  1  misaligned-target trap taken last cycle (reg pulse)
o_bad_addr  out  ADDR_WIDTH  offending target of last trap (reg, sticky)
o_cnt_redirect, o_cnt_rollback, o_cnt_discard, o_cnt_inject  out  CNT_WIDTH  perf counters

Behaviour:
- Reset: nreset is synchronous, active-low; clock is clk. Reset values: o_if_pc=RESET_ADDR, o_pm_flush=o_id_flush=o_ex_flush=1, o_redirect=0, o_fetch_misaligned=0, o_bad_addr=0, counters=0.
- Reset mid-operation overrides everything, including stall.
- Stall: while i_stall=1, all registers hold and all inputs are ignored; decisions are sampled only on cycles with i_stall=0.
- Next-PC priority, unstalled cycle:
  - 1) ex_redir = i_ex_jump_branch && !i_discard_jump → i_ex_jump_addr.
  - 2) i_rollback_jump → i_rollback_jump_addr.
  - 3) i_if_inject → i_if_inject_addr.
  - 4) o_if_pc+4, wrapping modulo 2^ADDR_WIDTH.
- Simultaneous i_ex_jump_branch and i_rollback_jump: jump wins; SIMULATION builds flag an assertion error.
- Alignment: a target is misaligned when addr[1:0]!=0.
  - Misaligned class 1/2 target: PC←TRAP_ADDR, o_fetch_misaligned=1 next cycle, o_bad_addr←target, treated as a redirect for kill flags.
  - Misaligned inject target: inject ignored, falls to PC+4, no trap, no PM kill.
- Kill flags (one cycle latency), on a class 1/2 redirect or trap:
  - next cycle pm=id=ex=1; o_redirect=1.
- Kill flags, on an accepted inject with i_pm_flush_req=1:
  - next cycle pm=1, id←old pm, ex←old id.
  - i_pm_flush_req without accepted inject is ignored.
- Kill flags, otherwise: shift, ex←id, id←pm, pm←0.
- Discarded jump: no PC change, no kill, sequential/inject path continues.
- Pulses o_redirect/o_fetch_misaligned clear on the next unstalled cycle; they hold during stall.

Optional Feature:
- Macro FETCH_PERF_COUNTERS_EN.
- Defined: four counters, each incremented once per unstalled cycle on its event, saturating at all-ones; cleared by reset. Events:
  - redirect: class 1 or trap
  - rollback: class 2 taken
  - discard: i_ex_jump_branch && i_discard_jump
  - inject: accepted inject
- Undefined: counter ports present, tied to 0, no counter flops.

Test Plan:
- Reset, no events, 4 unstalled cycles (ADDR_WIDTH=64, RESET_ADDR=0):
  - o_if_pc = 0,4,8,12.
  - flush flags go (1,1,1)→(0,1,1)→(0,0,1)→(0,0,0).
- EX redirect: i_ex_jump_branch=1, addr=0x2000, discard=0 at PC=0x40:
  - next cycle o_if_pc=0x2000, pm/id/ex flush=1, o_redirect=1.
  - with discard=1 instead: o_if_pc=0x44, no flush, discard counter +1.
- Inject with i_pm_flush_req=1, addr=0x300, prior flags (0,0,0):
  - o_if_pc=0x300, flags (1,0,0), then (0,1,0).
  - same with addr=0x302: o_if_pc=PC+4, no trap, flags stay 0.
- Stall for 3 cycles with i_ex_jump_branch=1 asserted throughout:
  - PC and flags unchanged during stall.
  - redirect applied on the first unstalled cycle only.
- Rollback to 0x1006:
  - o_if_pc=TRAP_ADDR, o_fetch_misaligned=1, o_bad_addr=0x1006, all flush=1.
- Wrap: PC=2^64-4 with no events → o_if_pc=0; reset asserted while stalled → o_if_pc=RESET_ADDR next edge.

Source files
------------

// File: rtl/riscv_fetch_pc_sequencer.sv
// Fetch-stage next-PC sequencer: EX redirect > rollback > inject > PC+4, per-stage kill flags, misaligned-target trap.
// Optional fetch performance counters are built when FETCH_PERF_COUNTERS_EN is defined.
module riscv_fetch_pc_sequencer #(
  parameter int unsigned           ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
  parameter logic [ADDR_WIDTH-1:0] TRAP_ADDR  = ADDR_WIDTH'('h100),
  parameter int unsigned           CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  i_stall,
  input  logic                  i_ex_jump_branch,
  input  logic [ADDR_WIDTH-1:0] i_ex_jump_addr,
  input  logic                  i_discard_jump,
  input  logic                  i_rollback_jump,
  input  logic [ADDR_WIDTH-1:0] i_rollback_jump_addr,
  input  logic                  i_pm_flush_req,
  input  logic                  i_if_inject,
  input  logic [ADDR_WIDTH-1:0] i_if_inject_addr,
  output logic [ADDR_WIDTH-1:0] o_if_pc,
  output logic                  o_pm_flush,
  output logic                  o_id_flush,
  output logic                  o_ex_flush,
  output logic                  o_redirect,
  output logic                  o_fetch_misaligned,
  output logic [ADDR_WIDTH-1:0] o_bad_addr,
  output logic [CNT_WIDTH-1:0]  o_cnt_redirect,
  output logic [CNT_WIDTH-1:0]  o_cnt_rollback,
  output logic [CNT_WIDTH-1:0]  o_cnt_discard,
  output logic [CNT_WIDTH-1:0]  o_cnt_inject
);

  logic                  ex_redir;
  logic                  arch_redir;
  logic [ADDR_WIDTH-1:0] arch_target;
  logic                  target_misaligned;
  logic                  inject_ok;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic                  pm_flush_next;
  logic                  id_flush_next;
  logic                  ex_flush_next;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    ex_redir          = i_ex_jump_branch && !i_discard_jump;
    arch_redir        = ex_redir || i_rollback_jump;
    arch_target       = ex_redir ? i_ex_jump_addr : i_rollback_jump_addr;
    target_misaligned = arch_redir && (arch_target[1:0] != 2'b00);
    // A misaligned predictor target is simply not taken; fetch falls through sequentially.
    inject_ok         = !arch_redir && i_if_inject && (i_if_inject_addr[1:0] == 2'b00);

    next_pc       = o_if_pc + ADDR_WIDTH'(4);
    pm_flush_next = 1'b0;
    id_flush_next = o_pm_flush;
    ex_flush_next = o_id_flush;

    if (target_misaligned) begin
      next_pc = TRAP_ADDR;
    end else if (arch_redir) begin
      next_pc = arch_target;
    end else if (inject_ok) begin
      next_pc = i_if_inject_addr;
    end

    if (arch_redir) begin
      pm_flush_next = 1'b1;
      id_flush_next = 1'b1;
      ex_flush_next = 1'b1;
    end else if (inject_ok && i_pm_flush_req) begin
      pm_flush_next = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      o_if_pc            <= RESET_ADDR;
      o_pm_flush         <= 1'b1;
      o_id_flush         <= 1'b1;
      o_ex_flush         <= 1'b1;
      o_redirect         <= 1'b0;
      o_fetch_misaligned <= 1'b0;
      o_bad_addr         <= '0;
    end else if (!i_stall) begin
      o_if_pc            <= next_pc;
      o_pm_flush         <= pm_flush_next;
      o_id_flush         <= id_flush_next;
      o_ex_flush         <= ex_flush_next;
      o_redirect         <= arch_redir;
      o_fetch_misaligned <= target_misaligned;
      if (target_misaligned) begin
        o_bad_addr <= arch_target;
      end
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  logic [CNT_WIDTH-1:0] cnt_redirect;
  logic [CNT_WIDTH-1:0] cnt_rollback;
  logic [CNT_WIDTH-1:0] cnt_discard;
  logic [CNT_WIDTH-1:0] cnt_inject;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt, input logic ev);
    return (ev && !(&cnt)) ? cnt + CNT_WIDTH'(1) : cnt;
  endfunction

  // A trapped rollback counts as a redirect, not as a rollback.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      cnt_redirect <= '0;
      cnt_rollback <= '0;
      cnt_discard  <= '0;
      cnt_inject   <= '0;
    end else if (!i_stall) begin
      cnt_redirect <= sat_inc(cnt_redirect, ex_redir || target_misaligned);
      cnt_rollback <= sat_inc(cnt_rollback, !ex_redir && i_rollback_jump && !target_misaligned);
      cnt_discard  <= sat_inc(cnt_discard, i_ex_jump_branch && i_discard_jump);
      cnt_inject   <= sat_inc(cnt_inject, inject_ok);
    end
  end

  assign o_cnt_redirect = cnt_redirect;
  assign o_cnt_rollback = cnt_rollback;
  assign o_cnt_discard  = cnt_discard;
  assign o_cnt_inject   = cnt_inject;
`else
  assign o_cnt_redirect = '0;
  assign o_cnt_rollback = '0;
  assign o_cnt_discard  = '0;
  assign o_cnt_inject   = '0;
`endif

`ifdef SIMULATION
  always_ff @(posedge clk) begin
    if (nreset && !i_stall) begin
      assert (!(i_ex_jump_branch && i_rollback_jump))
        else $error("EX jump and predictor rollback asserted in the same cycle");
    end
  end
`endif

endmodule

// File: tb/tb_riscv_fetch_pc_sequencer.sv
// Bench for riscv_fetch_pc_sequencer: directed literal checks plus randomized traffic against a behavioural model.
module tb_riscv_fetch_pc_sequencer;

  localparam int          AW      = 64;
  localparam int          CW      = 4;
  localparam logic [63:0] RST_PC  = 64'h0;
  localparam logic [63:0] TRAP_PC = 64'h100;
  localparam int          CMAX    = (1 << CW) - 1;
`ifdef FETCH_PERF_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          nreset;
  logic          i_stall;
  logic          i_ex_jump_branch;
  logic [AW-1:0] i_ex_jump_addr;
  logic          i_discard_jump;
  logic          i_rollback_jump;
  logic [AW-1:0] i_rollback_jump_addr;
  logic          i_pm_flush_req;
  logic          i_if_inject;
  logic [AW-1:0] i_if_inject_addr;
  logic [AW-1:0] o_if_pc;
  logic          o_pm_flush;
  logic          o_id_flush;
  logic          o_ex_flush;
  logic          o_redirect;
  logic          o_fetch_misaligned;
  logic [AW-1:0] o_bad_addr;
  logic [CW-1:0] o_cnt_redirect;
  logic [CW-1:0] o_cnt_rollback;
  logic [CW-1:0] o_cnt_discard;
  logic [CW-1:0] o_cnt_inject;

  always #5 clk = ~clk;

  riscv_fetch_pc_sequencer #(
    .ADDR_WIDTH(AW),
    .RESET_ADDR(RST_PC),
    .TRAP_ADDR (TRAP_PC),
    .CNT_WIDTH (CW)
  ) dut (
    .clk                 (clk),
    .nreset              (nreset),
    .i_stall             (i_stall),
    .i_ex_jump_branch    (i_ex_jump_branch),
    .i_ex_jump_addr      (i_ex_jump_addr),
    .i_discard_jump      (i_discard_jump),
    .i_rollback_jump     (i_rollback_jump),
    .i_rollback_jump_addr(i_rollback_jump_addr),
    .i_pm_flush_req      (i_pm_flush_req),
    .i_if_inject         (i_if_inject),
    .i_if_inject_addr    (i_if_inject_addr),
    .o_if_pc             (o_if_pc),
    .o_pm_flush          (o_pm_flush),
    .o_id_flush          (o_id_flush),
    .o_ex_flush          (o_ex_flush),
    .o_redirect          (o_redirect),
    .o_fetch_misaligned  (o_fetch_misaligned),
    .o_bad_addr          (o_bad_addr),
    .o_cnt_redirect      (o_cnt_redirect),
    .o_cnt_rollback      (o_cnt_rollback),
    .o_cnt_discard       (o_cnt_discard),
    .o_cnt_inject        (o_cnt_inject)
  );

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model: pipeline kill bits indexed 0=PM, 1=ID, 2=EX; counters 0..3 = redirect, rollback, discard, inject.
  logic [63:0] m_pc;
  logic [63:0] m_bad;
  bit          m_kill [3];
  bit          m_redir;
  bit          m_mis;
  int          m_cnt  [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bump(input int idx, input bit ev);
    if (CNT_EN && ev && m_cnt[idx] < CMAX) m_cnt[idx]++;
  endtask

  task automatic model_step();
    logic [63:0] tgt;
    bit ex_r, arch, mis, inj_ok;
    if (!nreset) begin
      m_pc = RST_PC; m_bad = 64'h0; m_redir = 0; m_mis = 0;
      m_kill = '{1'b1, 1'b1, 1'b1};
      m_cnt  = '{0, 0, 0, 0};
      return;
    end
    if (i_stall) return;
    ex_r   = i_ex_jump_branch && !i_discard_jump;
    arch   = ex_r || i_rollback_jump;
    tgt    = ex_r ? i_ex_jump_addr : i_rollback_jump_addr;
    mis    = arch && (tgt % 4 != 0);
    inj_ok = !arch && i_if_inject && (i_if_inject_addr % 4 == 0);
    bump(0, ex_r || mis);
    bump(1, i_rollback_jump && !ex_r && !mis);
    bump(2, i_ex_jump_branch && i_discard_jump);
    bump(3, inj_ok);
    m_redir = arch;
    m_mis   = mis;
    if (mis) begin
      m_pc  = TRAP_PC;
      m_bad = tgt;
    end else if (arch)   m_pc = tgt;
    else if (inj_ok)     m_pc = i_if_inject_addr;
    else                 m_pc = m_pc + 64'd4;
    if (arch) begin
      m_kill = '{1'b1, 1'b1, 1'b1};
    end else begin
      m_kill[2] = m_kill[1];
      m_kill[1] = m_kill[0];
      m_kill[0] = inj_ok && i_pm_flush_req;
    end
  endtask

  // Compare process: DUT against model on every falling edge once reset has been applied.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_pc", o_if_pc, m_pc);
      check("model_flush", {61'h0, o_pm_flush, o_id_flush, o_ex_flush}, {61'h0, m_kill[0], m_kill[1], m_kill[2]});
      check("model_pulses", {62'h0, o_redirect, o_fetch_misaligned}, {62'h0, m_redir, m_mis});
      check("model_bad_addr", o_bad_addr, m_bad);
      check("model_cnt_redirect", 64'(o_cnt_redirect), 64'(m_cnt[0]));
      check("model_cnt_rollback", 64'(o_cnt_rollback), 64'(m_cnt[1]));
      check("model_cnt_discard", 64'(o_cnt_discard), 64'(m_cnt[2]));
      check("model_cnt_inject", 64'(o_cnt_inject), 64'(m_cnt[3]));
    end
  end

  task automatic clear_inputs();
    i_stall = 0; i_ex_jump_branch = 0; i_ex_jump_addr = '0; i_discard_jump = 0;
    i_rollback_jump = 0; i_rollback_jump_addr = '0; i_pm_flush_req = 0;
    i_if_inject = 0; i_if_inject_addr = '0;
  endtask

  // One clock: DUT and model both see the inputs at the rising edge; return just after the falling edge.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_flags(input string name, input logic [2:0] exp);
    check(name, {61'h0, o_pm_flush, o_id_flush, o_ex_flush}, {61'h0, exp});
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    a = {$urandom, $urandom};
    if ($urandom_range(0, 7) == 0) a[63:12] = '1;
    a[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
    return a;
  endfunction

  initial begin
    clear_inputs();
    nreset = 0;
    step();
    chk_en = 1'b1;

    check("reset_pc", o_if_pc, 64'h0);
    check_flags("reset_flags", 3'b111);
    check("reset_redirect", {63'h0, o_redirect}, 64'h0);
    check("reset_misaligned", {63'h0, o_fetch_misaligned}, 64'h0);
    check("reset_bad_addr", o_bad_addr, 64'h0);

    nreset = 1;
    step(); check("seq_pc_1", o_if_pc, 64'h4);  check_flags("seq_flags_1", 3'b011);
    step(); check("seq_pc_2", o_if_pc, 64'h8);  check_flags("seq_flags_2", 3'b001);
    step(); check("seq_pc_3", o_if_pc, 64'hc);  check_flags("seq_flags_3", 3'b000);

    // EX redirect from PC 0x40
    i_if_inject = 1; i_if_inject_addr = 64'h40;
    step(); check("inj_pc_40", o_if_pc, 64'h40);
    clear_inputs(); i_ex_jump_branch = 1; i_ex_jump_addr = 64'h2000;
    step();
    check("ex_redir_pc", o_if_pc, 64'h2000);
    check_flags("ex_redir_flags", 3'b111);
    check("ex_redir_pulse", {63'h0, o_redirect}, 64'h1);

    // Discarded jump from PC 0x40
    clear_inputs(); i_if_inject = 1; i_if_inject_addr = 64'h40;
    step();
    clear_inputs(); i_ex_jump_branch = 1; i_ex_jump_addr = 64'h2000; i_discard_jump = 1;
    step();
    check("discard_pc", o_if_pc, 64'h44);
    check("discard_pm", {63'h0, o_pm_flush}, 64'h0);
    check("discard_redirect", {63'h0, o_redirect}, 64'h0);
    check("discard_cnt", 64'(o_cnt_discard), CNT_EN ? 64'h1 : 64'h0);

    // Inject with PM flush request, then a misaligned inject
    clear_inputs(); step();
    check_flags("pre_inject_flags", 3'b000);
    i_if_inject = 1; i_if_inject_addr = 64'h300; i_pm_flush_req = 1;
    step();
    check("inject_pc", o_if_pc, 64'h300);
    check_flags("inject_flags_a", 3'b100);
    clear_inputs(); step();
    check_flags("inject_flags_b", 3'b010);
    i_if_inject = 1; i_if_inject_addr = 64'h302; i_pm_flush_req = 1;
    step();
    check("mis_inject_pc", o_if_pc, 64'h308);
    check("mis_inject_pm", {63'h0, o_pm_flush}, 64'h0);
    check("mis_inject_trap", {63'h0, o_fetch_misaligned}, 64'h0);
    clear_inputs(); step();
    check("pre_stall_pc", o_if_pc, 64'h30c);

    // Stall with a pending EX jump
    i_stall = 1; i_ex_jump_branch = 1; i_ex_jump_addr = 64'h5000;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", o_if_pc, 64'h30c);
      check_flags("stall_flags", 3'b000);
    end
    i_stall = 0;
    step();
    check("post_stall_pc", o_if_pc, 64'h5000);
    check("post_stall_redirect", {63'h0, o_redirect}, 64'h1);
    i_stall = 1;
    step();
    check("pulse_hold_redirect", {63'h0, o_redirect}, 64'h1);
    check("pulse_hold_pc", o_if_pc, 64'h5000);
    clear_inputs(); step();
    check("after_redir_pc", o_if_pc, 64'h5004);
    check("after_redir_pulse", {63'h0, o_redirect}, 64'h0);

    // Misaligned rollback traps
    i_rollback_jump = 1; i_rollback_jump_addr = 64'h1006;
    step();
    check("trap_pc", o_if_pc, TRAP_PC);
    check("trap_pulse", {63'h0, o_fetch_misaligned}, 64'h1);
    check("trap_bad_addr", o_bad_addr, 64'h1006);
    check_flags("trap_flags", 3'b111);
    clear_inputs(); step();
    check("trap_clear", {63'h0, o_fetch_misaligned}, 64'h0);
    check("trap_bad_sticky", o_bad_addr, 64'h1006);
    check("trap_next_pc", o_if_pc, 64'h104);

    // PC wrap
    i_if_inject = 1; i_if_inject_addr = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    clear_inputs(); step();
    check("wrap_pc", o_if_pc, 64'h0);

    // Reset while stalled
    i_if_inject = 1; i_if_inject_addr = 64'h7770;
    step();
    clear_inputs(); i_stall = 1; nreset = 0;
    step();
    check("stall_reset_pc", o_if_pc, RST_PC);
    check_flags("stall_reset_flags", 3'b111);
    check("stall_reset_bad", o_bad_addr, 64'h0);
    nreset = 1; i_stall = 0;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      clear_inputs();
      nreset               = ($urandom_range(0, 299) != 0);
      i_stall              = ($urandom_range(0, 4) == 0);
      i_ex_jump_branch     = ($urandom_range(0, 5) == 0);
      i_discard_jump       = ($urandom_range(0, 2) == 0);
      i_ex_jump_addr       = rand_addr();
      i_rollback_jump      = !i_ex_jump_branch && ($urandom_range(0, 7) == 0);
      i_rollback_jump_addr = rand_addr();
      i_if_inject          = ($urandom_range(0, 3) == 0);
      i_if_inject_addr     = rand_addr();
      i_pm_flush_req       = ($urandom_range(0, 1) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
